// File: rtl/occupancy_pkg.sv
// Shared types and constants for the parking-lot occupancy counter.
// No logic; imported by gate_fsm and occupancy_counter.
package occupancy_pkg;

    localparam int DIGIT_W = 5;

    typedef logic [DIGIT_W-1:0] digit_t;

    localparam digit_t BCD_MAX  = digit_t'(9);
    localparam digit_t BCD_ZERO = digit_t'(0);
    localparam digit_t BCD_ONE  = digit_t'(1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        EN1  = 3'd1,
        EN2  = 3'd2,
        EN3  = 3'd3,
        EX1  = 3'd4,
        EX2  = 3'd5,
        EX3  = 3'd6,
        WAIT = 3'd7
    } gate_state_t;

    // Sensor pair as seen by the FSM, written {sa, sb}.
    localparam logic [1:0] AB_CLEAR = 2'b00;
    localparam logic [1:0] AB_OUTER = 2'b10;
    localparam logic [1:0] AB_INNER = 2'b01;
    localparam logic [1:0] AB_BOTH  = 2'b11;

endpackage

// File: rtl/gate_fsm.sv
// Synchronizes the two gate sensors and classifies full passages as enter/exit.
// Pulse appears 3 edges after the raw inputs clear; no backpressure (free-running).
module gate_fsm
    import occupancy_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic a,
    input  logic b,
    output logic car_enter,
    output logic car_exit
);

    logic [1:0]  meta;
    logic [1:0]  sync;
    gate_state_t state;
    gate_state_t state_nxt;
    logic        enter_nxt;
    logic        exit_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= 2'b00;
            sync <= 2'b00;
        end else begin
            meta <= {a, b};
            sync <= meta;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            car_enter <= 1'b0;
            car_exit  <= 1'b0;
        end else begin
            state     <= state_nxt;
            car_enter <= enter_nxt;
            car_exit  <= exit_nxt;
        end
    end

    // Any input not named for a state holds that state.
    always_comb begin
        state_nxt = state;
        enter_nxt = 1'b0;
        exit_nxt  = 1'b0;
        unique case (state)
            IDLE: begin
                if (sync == AB_OUTER)      state_nxt = EN1;
                else if (sync == AB_INNER) state_nxt = EX1;
                else if (sync == AB_BOTH)  state_nxt = WAIT;
            end
            EN1: begin
                if (sync == AB_BOTH)       state_nxt = EN2;
                else if (sync == AB_CLEAR) state_nxt = IDLE;
                else if (sync == AB_INNER) state_nxt = WAIT;
            end
            EN2: begin
                if (sync == AB_INNER)      state_nxt = EN3;
                else if (sync == AB_OUTER) state_nxt = EN1;
                else if (sync == AB_CLEAR) state_nxt = IDLE;
            end
            EN3: begin
                if (sync == AB_CLEAR) begin
                    state_nxt = IDLE;
                    enter_nxt = 1'b1;
                end else if (sync == AB_BOTH) begin
                    state_nxt = EN2;
                end else if (sync == AB_OUTER) begin
                    state_nxt = WAIT;
                end
            end
            EX1: begin
                if (sync == AB_BOTH)       state_nxt = EX2;
                else if (sync == AB_CLEAR) state_nxt = IDLE;
                else if (sync == AB_OUTER) state_nxt = WAIT;
            end
            EX2: begin
                if (sync == AB_OUTER)      state_nxt = EX3;
                else if (sync == AB_INNER) state_nxt = EX1;
                else if (sync == AB_CLEAR) state_nxt = IDLE;
            end
            EX3: begin
                if (sync == AB_CLEAR) begin
                    state_nxt = IDLE;
                    exit_nxt  = 1'b1;
                end else if (sync == AB_BOTH) begin
                    state_nxt = EX2;
                end else if (sync == AB_INNER) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (sync == AB_CLEAR) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: rtl/occupancy_counter.sv
// Saturating occupancy count with registered BCD digits and full/empty flags.
// Count updates one edge after a car_enter/car_exit pulse; no backpressure.
module occupancy_counter
    import occupancy_pkg::*;
#(
    parameter int CAPACITY = 25,
    parameter int CNT_W    = 7
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               a,
    input  logic               b,
    output logic               car_enter,
    output logic               car_exit,
    output logic [CNT_W-1:0]   count,
    output logic [DIGIT_W-1:0] ones_digit,
    output logic [DIGIT_W-1:0] tens_digit,
    output logic               full,
    output logic               empty
);

    localparam logic [CNT_W-1:0] CAP_V = CNT_W'(CAPACITY);
    localparam logic [CNT_W-1:0] ONE_V = CNT_W'(1);

    logic do_inc;
    logic do_dec;

    gate_fsm u_gate_fsm (
        .clk       (clk),
        .reset     (reset),
        .a         (a),
        .b         (b),
        .car_enter (car_enter),
        .car_exit  (car_exit)
    );

    // Saturation: requests at the limits are dropped, never wrapped.
    assign do_inc = car_enter && (count < CAP_V);
    assign do_dec = car_exit && (count != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            count      <= '0;
            ones_digit <= BCD_ZERO;
            tens_digit <= BCD_ZERO;
            full       <= 1'b0;
            empty      <= 1'b1;
        end else if (do_inc) begin
            count <= count + ONE_V;
            if (ones_digit == BCD_MAX) begin
                ones_digit <= BCD_ZERO;
                tens_digit <= tens_digit + BCD_ONE;
            end else begin
                ones_digit <= ones_digit + BCD_ONE;
            end
            full  <= (count == CAP_V - ONE_V);
            empty <= 1'b0;
        end else if (do_dec) begin
            count <= count - ONE_V;
            if (ones_digit == BCD_ZERO) begin
                ones_digit <= BCD_MAX;
                tens_digit <= tens_digit - BCD_ONE;
            end else begin
                ones_digit <= ones_digit - BCD_ONE;
            end
            full  <= 1'b0;
            empty <= (count == ONE_V);
        end
    end

endmodule

// File: tb/tb_occupancy_counter.sv
// Randomized passage bench for occupancy_counter against an arithmetic occupancy model.
module tb_occupancy_counter;

    localparam int CAPACITY = 25;
    localparam int CNT_W    = 7;

    logic             clk = 1'b0;
    logic             reset;
    logic             a;
    logic             b;
    logic             car_enter;
    logic             car_exit;
    logic [CNT_W-1:0] count;
    logic [4:0]       ones_digit;
    logic [4:0]       tens_digit;
    logic             full;
    logic             empty;

    occupancy_counter #(.CAPACITY(CAPACITY), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .a          (a),
        .b          (b),
        .car_enter  (car_enter),
        .car_exit   (car_exit),
        .count      (count),
        .ones_digit (ones_digit),
        .tens_digit (tens_digit),
        .full       (full),
        .empty      (empty)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int model_count = 0;
    int n_enter = 0;
    int n_exit = 0;
    int hold_idx = 0;
    int pulse_off = -1;
    int cnt_at3 = 0;
    int cnt_at4 = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        hold_idx++;
        if (car_enter) n_enter++;
        if (car_exit) n_exit++;
        if ((car_enter || car_exit) && pulse_off < 0) pulse_off = hold_idx;
        if (hold_idx == 3) cnt_at3 = int'(count);
        if (hold_idx == 4) cnt_at4 = int'(count);
        chk("pulse_exclusive", int'(car_enter & car_exit), 0);
    endtask

    task automatic drive(input logic [1:0] ab, input int hold);
        {a, b} = ab;
        repeat (hold) tick();
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "_count"}, int'(count), model_count);
        chk({tag, "_ones"},  int'(ones_digit), model_count % 10);
        chk({tag, "_tens"},  int'(tens_digit), model_count / 10);
        chk({tag, "_full"},  int'(full), int'(model_count == CAPACITY));
        chk({tag, "_empty"}, int'(empty), int'(model_count == 0));
    endtask

    // kind selects a sensor sequence; ev: 0 none, 1 enter, 2 exit.
    task automatic run_passage(input int kind, input int fixed_hold);
        logic [1:0] seq[$];
        int ev;
        int e0;
        int x0;
        int prev;
        case (kind)
            0: begin seq = '{2'b10, 2'b11, 2'b01, 2'b00}; ev = 1; end
            1: begin seq = '{2'b01, 2'b11, 2'b10, 2'b00}; ev = 2; end
            2: begin seq = '{2'b10, 2'b00}; ev = 0; end
            3: begin seq = '{2'b10, 2'b11, 2'b10, 2'b00}; ev = 0; end
            4: begin seq = '{2'b11, 2'b01, 2'b00}; ev = 0; end
            5: begin seq = '{2'b10, 2'b11, 2'b01, 2'b11, 2'b01, 2'b00}; ev = 1; end
            6: begin seq = '{2'b01, 2'b11, 2'b01, 2'b00}; ev = 0; end
            7: begin seq = '{2'b10, 2'b11, 2'b01, 2'b10, 2'b00}; ev = 0; end
            8: begin seq = '{2'b01, 2'b11, 2'b10, 2'b11, 2'b10, 2'b00}; ev = 2; end
            default: begin seq = '{2'b10, 2'b01, 2'b00}; ev = 0; end
        endcase
        e0 = n_enter;
        x0 = n_exit;
        prev = model_count;
        pulse_off = -1;
        for (int i = 0; i < seq.size() - 1; i++)
            drive(seq[i], (fixed_hold > 0) ? fixed_hold : int'($urandom_range(1, 4)));
        hold_idx = 0;
        drive(seq[seq.size() - 1], 6);
        if (ev == 1 && model_count < CAPACITY) model_count++;
        if (ev == 2 && model_count > 0) model_count--;
        chk("enter_pulses", n_enter - e0, int'(ev == 1));
        chk("exit_pulses", n_exit - x0, int'(ev == 2));
        if (ev != 0) begin
            chk("pulse_latency", pulse_off, 3);
            chk("count_not_early", cnt_at3, prev);
            chk("count_at_n3", cnt_at4, model_count);
        end
        check_outputs("passage");
    endtask

    initial begin
        reset = 1'b1;
        {a, b} = 2'b00;
        repeat (3) tick();
        check_outputs("reset");
        chk("reset_enter", int'(car_enter), 0);
        chk("reset_exit", int'(car_exit), 0);
        reset = 1'b0;
        n_enter = 0;
        n_exit = 0;
        repeat (10) tick();
        check_outputs("idle");
        chk("idle_pulses", n_enter + n_exit, 0);

        for (int i = 0; i < 10; i++) run_passage(0, 3);
        chk("ten_ones", int'(ones_digit), 0);
        chk("ten_tens", int'(tens_digit), 1);
        run_passage(1, 3);
        chk("borrow_count", int'(count), 9);
        chk("borrow_ones", int'(ones_digit), 9);
        chk("borrow_tens", int'(tens_digit), 0);

        for (int k = 2; k <= 9; k++) run_passage(k, 3);

        for (int i = 0; i < 60; i++) run_passage(int'($urandom_range(0, 9)), 0);

        for (int i = 0; i < 27; i++) run_passage(0, 3);
        chk("sat_count", int'(count), 25);
        chk("sat_full", int'(full), 1);
        chk("sat_tens", int'(tens_digit), 2);
        chk("sat_ones", int'(ones_digit), 5);
        for (int i = 0; i < 26; i++) run_passage(1, 3);
        chk("drain_count", int'(count), 0);
        chk("drain_empty", int'(empty), 1);

        // Build some occupancy, then abandon a passage in EN2 with reset.
        for (int i = 0; i < 3; i++) run_passage(0, 3);
        drive(2'b10, 3);
        drive(2'b11, 3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_count = 0;
        check_outputs("mid_reset");
        n_enter = 0;
        n_exit = 0;
        drive(2'b01, 3);
        drive(2'b00, 6);
        chk("post_reset_pulses", n_enter + n_exit, 0);
        check_outputs("post_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/occupancy_counter.md
Name: occupancy_counter

Overview:
- Upstream feeder for the 7-segment display decoders in the parking-lot design.
- Watches two gate sensors, a (outer) and b (inner), and classifies complete car passages as enter or exit.
- Keeps a saturating occupancy count and publishes it as registered BCD ones/tens digits.
- Digits are 5 bits wide so they connect directly to the existing 5-bit display-decoder input. Also drives full/empty flags for status LEDs.

Parameters:
- CAPACITY, 25, maximum occupancy. Legal range 1..99.
- CNT_W, 7, width of the binary count. Must satisfy 2**CNT_W > CAPACITY.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- a  input  1  outer sensor, raw and asynchronous, 1 = beam blocked
- b  input  1  inner sensor, raw and asynchronous, 1 = beam blocked
- car_enter  output  1  one-cycle pulse on each completed entry
- car_exit  output  1  one-cycle pulse on each completed exit
- count  output  CNT_W  binary occupancy
- ones_digit  output  5  BCD ones digit, values 0..9, bits [4] always 0
- tens_digit  output  5  BCD tens digit, values 0..9, bits [4] always 0
- full  output  1  high when count == CAPACITY
- empty  output  1  high when count == 0

Behaviour:
- Clock and reset:
  - One clock, clk. Reset is synchronous and active-high, named reset.
  - Reset values: both synchronizer stages 0, FSM in IDLE, car_enter=0, car_exit=0, count=0, ones_digit=0, tens_digit=0, full=0, empty=1.
  - Reset asserted mid-passage discards the passage and produces no pulse.
- Input synchronization: a and b each pass through a 2-flop synchronizer. The FSM sees only the synchronized pair {sa, sb}.
- FSM states: IDLE, EN1, EN2, EN3, EX1, EX2, EX3, WAIT. Inputs are written as {sa,sb}. Any input not listed for a state holds that state.
  - IDLE: 10 -> EN1; 01 -> EX1; 11 -> WAIT.
  - EN1: 11 -> EN2; 00 -> IDLE (abort); 01 -> WAIT.
  - EN2: 01 -> EN3; 10 -> EN1 (back-up); 00 -> IDLE.
  - EN3: 00 -> IDLE and assert car_enter; 11 -> EN2; 10 -> WAIT.
  - EX1/EX2/EX3: mirror of EN1/EN2/EN3 with a and b swapped. EX3 with 00 -> IDLE and assert car_exit.
  - WAIT: 00 -> IDLE. No pulse is ever produced from WAIT.
- Pulses:
  - car_enter and car_exit are registered and high for exactly one cycle.
  - They are never high in the same cycle.
- Latency:
  - The raw inputs become 00 before edge N.
  - car_enter/car_exit is high during the cycle following edge N+2.
  - count, the digits and the flags update at edge N+3.
- Counter:
  - car_enter with count < CAPACITY: count+1, with the BCD ones/tens incremented together. Ones 9 -> 0 carries into tens.
  - car_exit with count > 0: count-1. Ones 0 -> 9 borrows from tens.
  - car_enter while full, or car_exit while empty: ignored. count and digits hold; no wrap-around.
  - full and empty are registered and updated on the same edge as count.
- Invariant: count == 10*tens_digit + ones_digit at all times.

Decomposition:
- Package occupancy_pkg holds:
  - typedef enum logic [2:0] gate_state_t with the eight FSM states;
  - localparam DIGIT_W = 5;
  - localparam BCD_MAX = 9.
- Sub-module gate_fsm contains the synchronizer, the state machine and the car_enter/car_exit pulse registers.
- Top level contains the saturating binary and BCD counters and the flags.
- Each digit output drives one display-decoder instance in the lab top level.

Test Plan:
- Reset, then hold a=b=0 for 10 cycles -> count=0, digits 0/0, empty=1, full=0, no pulses.
- Sequence 10,11,01,00, each held 3 cycles -> a single 1-cycle car_enter exactly 3 edges after the raw 00, and count=1 one edge later. Repeat to reach 10 -> ones_digit=0, tens_digit=1.
- Sequence 01,11,10,00 from count=10 -> a single car_exit, count=9, tens_digit=0, ones_digit=9 (borrow).
- Aborted and reversed passages, e.g. 10,11,10,00 and 10,00 -> no pulse, count unchanged. Also 11 from IDLE then 01,00 -> WAIT back to IDLE with no pulse.
- With CAPACITY=25, perform 27 entries -> count saturates at 25 (digits 2/5, full=1), the extra car_enter pulses are ignored. Then 26 exits -> count=0, empty=1, no underflow.
- Assert reset during EN2 -> next cycle FSM is IDLE. Completing the sensor sequence afterwards (01,00) produces no pulse, and count stays 0.
